// File: rtl/bus_ram_responder.sv
// bus_ram_responder
// Single-port 64-bit RAM responder for the internal memory bus. It accepts
// one request at a time, waits a fixed number of cycles, then performs a
// size-aware load (with sign or zero extension) or a byte-merged store. It
// signals completion with a one-cycle o_HREADY pulse.
//
// Parameters:
//   DEPTH_LOG2  - RAM holds 2^DEPTH_LOG2 64-bit doublewords
//   BASE_ADDR   - byte address of doubleword 0
//   WAIT_CYCLES - wait states between accept and response (0..15)
//
// Ports:
//   CLK        in   clock, rising edge
//   RESET      in   asynchronous, active-low reset
//   i_HTRANS   in   request valid (sampled in IDLE or RESP only)
//   i_HADDR    in   byte address
//   i_HWRITE   in   1 = store, 0 = load
//   i_HSIZE    in   [1:0] byte/half/word/double, [2] = zero-extend load
//   i_HWDATA   in   right-aligned store data
//   o_HRDATA   out  load result, nonzero only while o_HREADY = 1
//   o_HREADY   out  one-cycle completion pulse
//   o_HRESP    out  error flag, valid only while o_HREADY = 1
//
// Optional feature: define BUS_RAM_RESP_ERR_EN to flag misaligned and
// out-of-range requests with o_HRESP. Without it, o_HRESP is always 0. The
// index then wraps modulo the RAM depth, and misaligned addresses are
// rounded down to the access size.
module bus_ram_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_HTRANS,
  input  logic [63:0] i_HADDR,
  input  logic        i_HWRITE,
  input  logic [2:0]  i_HSIZE,
  input  logic [63:0] i_HWDATA,
  output logic [63:0] o_HRDATA,
  output logic        o_HREADY,
  output logic        o_HRESP
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_accept;
  logic   w_access;

  logic [3:0]  r_wait_cnt;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_write;
  logic [2:0]  r_size;

  logic [63:0] r_hrdata;
  logic        r_hresp;

  logic [63:0] r_mem [DEPTH];

  logic [63:0]           w_req_addr;
  logic [63:0]           w_req_wdata;
  logic                  w_req_write;
  logic [2:0]            w_req_size;
  logic [2:0]            w_lane_mask;
  logic [7:0]            w_size_bytes;
  logic [2:0]            w_lane;
  logic [DEPTH_LOG2-1:0] w_index;
  logic [63:0]           w_rd_word;
  logic [63:0]           w_shifted;
  logic                  w_sign_en;
  logic [63:0]           w_load_val;
  logic [7:0]            w_byte_en;
  logic [63:0]           w_wdata_sh;
  logic [63:0]           w_merged;
  logic                  w_err;
  logic                  w_mem_we;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A new request can be taken both from IDLE and from RESP, so requests can
  // run back-to-back with one response every WAIT_CYCLES + 1 cycles.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (i_HTRANS) begin
          w_accept     = 1'b1;
          w_next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == 4'd1) begin
          w_next_state = ST_RESP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Latch the request so the initiator may change its inputs during WAIT.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wait_cnt <= 4'd0;
      r_addr     <= 64'd0;
      r_wdata    <= 64'd0;
      r_write    <= 1'b0;
      r_size     <= 3'd0;
    end else if (w_accept) begin
      r_wait_cnt <= WAIT_INIT;
      r_addr     <= i_HADDR;
      r_wdata    <= i_HWDATA;
      r_write    <= i_HWRITE;
      r_size     <= i_HSIZE;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  // The access happens on the edge that enters RESP. With no wait states,
  // that is the accept edge itself, so the live inputs are used directly.
  assign w_access    = (w_next_state == ST_RESP);
  assign w_req_addr  = w_accept ? i_HADDR  : r_addr;
  assign w_req_wdata = w_accept ? i_HWDATA : r_wdata;
  assign w_req_write = w_accept ? i_HWRITE : r_write;
  assign w_req_size  = w_accept ? i_HSIZE  : r_size;

  always_comb begin
    w_lane_mask  = 3'b000;
    w_size_bytes = 8'hFF;
    case (w_req_size[1:0])
      2'd0: begin w_lane_mask = 3'b111; w_size_bytes = 8'h01; end
      2'd1: begin w_lane_mask = 3'b110; w_size_bytes = 8'h03; end
      2'd2: begin w_lane_mask = 3'b100; w_size_bytes = 8'h0F; end
      default: begin w_lane_mask = 3'b000; w_size_bytes = 8'hFF; end
    endcase
  end

  // The lane is rounded down to the access size, so a misaligned request
  // never straddles a doubleword boundary.
  assign w_lane    = w_req_addr[2:0] & w_lane_mask;
  assign w_index   = DEPTH_LOG2'((w_req_addr - BASE_ADDR) >> 3);
  assign w_rd_word = r_mem[w_index];
  assign w_shifted = w_rd_word >> {w_lane, 3'b000};
  assign w_sign_en = ~w_req_size[2];

  always_comb begin
    w_load_val = w_shifted;
    case (w_req_size[1:0])
      2'd0: w_load_val = {{56{w_sign_en & w_shifted[7]}},  w_shifted[7:0]};
      2'd1: w_load_val = {{48{w_sign_en & w_shifted[15]}}, w_shifted[15:0]};
      2'd2: w_load_val = {{32{w_sign_en & w_shifted[31]}}, w_shifted[31:0]};
      default: w_load_val = w_shifted;
    endcase
  end

  assign w_byte_en  = w_size_bytes << w_lane;
  assign w_wdata_sh = w_req_wdata << {w_lane, 3'b000};

  always_comb begin
    w_merged = w_rd_word;
    for (int b = 0; b < 8; b++) begin
      if (w_byte_en[b]) begin
        w_merged[b*8 +: 8] = w_wdata_sh[b*8 +: 8];
      end
    end
  end

`ifdef BUS_RAM_RESP_ERR_EN
  localparam logic [63:0] LIMIT_ADDR = BASE_ADDR + (64'd8 << DEPTH_LOG2);
  logic w_misaligned;
  logic w_out_of_range;
  assign w_misaligned   = (w_req_addr[2:0] & ~w_lane_mask) != 3'b000;
  assign w_out_of_range = (w_req_addr < BASE_ADDR) || (w_req_addr >= LIMIT_ADDR);
  assign w_err          = w_misaligned | w_out_of_range;
`else
  assign w_err = 1'b0;
`endif

  // Gating with RESET keeps a store from landing while reset is asserted.
  assign w_mem_we = w_access & w_req_write & ~w_err & RESET;

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_index] <= w_merged;
    end
  end

  // The response registers load only on the edge that enters RESP and clear
  // on every other edge. As a result, they are zero whenever o_HREADY is low.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hrdata <= 64'd0;
      r_hresp  <= 1'b0;
    end else if (w_access) begin
      r_hresp  <= w_err;
      r_hrdata <= (w_req_write || w_err) ? 64'd0 : w_load_val;
    end else begin
      r_hrdata <= 64'd0;
      r_hresp  <= 1'b0;
    end
  end

  assign o_HREADY = (r_state == ST_RESP);
  assign o_HRDATA = r_hrdata;
  assign o_HRESP  = r_hresp;

endmodule

// File: doc/bus_ram_responder.md
# bus_ram_responder

Single-port 64-bit RAM responder for the pipeline's internal memory bus, sitting behind the memory controller's arbitrated port as the counterpart to the fetch and load/store initiators. It accepts one request at a time (HTRANS high), inserts a fixed number of wait states, then performs a size-aware read or byte-merged write and signals completion with a one-cycle HREADY pulse. Load data is extracted from the addressed byte lanes and sign- or zero-extended, so the load/store stage receives register-ready values.

## Interface
- DEPTH_LOG2, 10: RAM holds 2^DEPTH_LOG2 64-bit doublewords.
- BASE_ADDR, 64'h8000_0000: byte address of doubleword 0.
- WAIT_CYCLES, 1: wait states between accept and response (0..15).
- CLK  in  1  clock, all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- HTRANS  in  1  request valid; sampled only in IDLE or RESP.
- HADDR  in  64  byte address.
- HWRITE  in  1  1 = store, 0 = load.
- HSIZE  in  3  [1:0] size: 0 byte, 1 half, 2 word, 3 double; [2] = 1 zero-extend load (ignored for stores).
- HWDATA  in  64  store data, right-aligned (LSBs hold the value).
- HRDATA  out  64  load result, valid only while HREADY = 1.
- HREADY  out  1  one-cycle completion pulse.
- HRESP  out  1  error flag, valid only while HREADY = 1.

## Operation
- States: IDLE, WAIT, RESP. Reset state IDLE; outputs HRDATA = 0, HREADY = 0, HRESP = 0.
- Accept: in IDLE or RESP with HTRANS = 1, latch HADDR, HWRITE, HSIZE, HWDATA; load the wait counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES > 0, otherwise to RESP.
- WAIT: the counter decrements each cycle; on reaching 1, go to RESP. HTRANS is ignored, and the initiator may drop or change its inputs.
- Access: performed on the edge entering RESP using the latched request. Index = (addr − BASE_ADDR) >> 3; lane = addr[2:0].
- Load: select 8/16/32/64 bits starting at byte lane; sign-extend from the MSB unless HSIZE[2] = 1; register the result into HRDATA.
- Store: merge HWDATA's low 1/2/4/8 bytes into the addressed lanes; other lanes are unchanged. HRDATA = 0 for stores.
- RESP: HREADY = 1 for exactly this cycle. Then go to IDLE, or accept a new request directly if HTRANS = 1.
- Reset mid-operation: the pending request is abandoned (no write), state returns to IDLE, and outputs clear immediately. RAM contents are never cleared by reset.

## Timing
- Request accepted at edge N gives HREADY high during cycle N + WAIT_CYCLES + 1.
- Back-to-back throughput: one response every WAIT_CYCLES + 1 cycles.
- HRDATA/HRESP hold 0 whenever HREADY = 0.
- A load issued after a store to the same address observes the stored data, since the store commits before its HREADY.

## Configuration
- BUS_RAM_RESP_ERR_EN defined: the following requests are errors.
  - Misaligned: half with addr[0] ≠ 0, word with addr[1:0] ≠ 0, double with addr[2:0] ≠ 0.
  - Out of range: addr < BASE_ADDR or addr ≥ BASE_ADDR + 8·2^DEPTH_LOG2.
  - On error: HRESP = 1 in RESP, no write, HRDATA = 0, normal latency.
- Not defined: HRESP is tied 0. The index wraps modulo 2^DEPTH_LOG2. Misaligned addresses are forced down to the size-aligned address before lane selection.

## Test plan
- Reset: RESET low mid-WAIT of a store of 64'hFF to 0x8000_0000 -> outputs 0, state IDLE; a later load of 0x8000_0000 returns the prior contents, and the store never lands.
- Double store/load: store 64'h1122_3344_5566_7788 at 0x8000_0010, then a double load -> same value, HREADY exactly 2 cycles after each accept (WAIT_CYCLES = 1).
- Byte merge plus sign extension:
  - Store byte 8'h80 at 0x8000_0013, then double load -> 64'h1122_3344_8066_7788.
  - Signed byte load at 0x8000_0013 -> 64'hFFFF_FFFF_FFFF_FF80.
  - Unsigned byte load (HSIZE = 3'b100) -> 64'h80.
- Back-to-back: HTRANS held high for 4 loads -> four HREADY pulses spaced 2 cycles apart; WAIT_CYCLES = 0 gives pulses on consecutive cycles.
- Errors, with BUS_RAM_RESP_ERR_EN defined:
  - Word store at 0x8000_0002 -> HRESP = 1, memory unchanged.
  - Load at 0x7FFF_FFF8 -> HRESP = 1, HRDATA = 0.
- Without the macro: the same word store at 0x8000_0002 writes lanes 0–3 of doubleword 0; HRESP = 0.
